muldiv_sequencer: RTL

- Iterative multiply/divide controller for the pipelined CPU, issued from the ID stage.
- Owns the HI/LO registers and sequences a shift-add multiplier / restoring divider over WIDTH cycles.
- Raises Stall back to ID whenever a new mul/div, an MFHI/MFLO read or an MTHI/MTLO write meets a busy unit.

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// ID-stage <-> multiply/divide sequencer bundle: issue, HI/LO access and status.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Rd_hilo;
  logic             Wr_hi;
  logic             Wr_lo;
  logic [WIDTH-1:0] Wdata;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Stall;
  logic             Done;

  modport master (
    output Start, Op, A, B, Rd_hilo, Wr_hi, Wr_lo, Wdata,
    input  Hi, Lo, Busy, Stall, Done
  );

  modport slave (
    input  Start, Op, A, B, Rd_hilo, Wr_hi, Wr_lo, Wdata,
    output Hi, Lo, Busy, Stall, Done
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply and
// restoring divide over WIDTH cycles, followed by a sign-fixup cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                Clk,
  input logic                Clrn,
  muldiv_sequencer_if.slave  bus
);
  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               dbz_q, dbz_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [DW-1:0]      prod_fix;

  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Stall = busy_q & (bus.Start | bus.Rd_hilo | bus.Wr_hi | bus.Wr_lo);

  // Next-state, datapath iteration and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;

    sign_a    = bus.Op[0] & bus.A[WIDTH-1];
    sign_b    = bus.Op[0] & bus.B[WIDTH-1];
    mag_a     = sign_a ? (~bus.A + WIDTH'(1)) : bus.A;
    mag_b     = sign_b ? (~bus.B + WIDTH'(1)) : bus.B;
    mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (a_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_shift[WIDTH-1:0] - b_q;
    prod_fix  = neg_res_q ? (~acc_q + DW'(1)) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          is_div_d  = bus.Op[1];
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          b_d       = mag_b;
          acc_d     = '0;
          cnt_d     = '0;
          if (bus.Op[1] && (bus.B == '0)) begin
            // Keep the raw dividend: it becomes HI on divide-by-zero
            dbz_d   = 1'b1;
            a_d     = bus.A;
            state_d = FIX;
          end else begin
            dbz_d   = 1'b0;
            a_d     = mag_a;
            state_d = CALC;
          end
        end else begin
          if (bus.Wr_hi) hi_d = bus.Wdata;
          if (bus.Wr_lo) lo_d = bus.Wdata;
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = {{WIDTH{1'b0}}, (div_ge ? div_rem : div_shift[WIDTH-1:0])};
          a_d   = {a_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          a_d   = a_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (dbz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? (~a_q + WIDTH'(1)) : a_q;
          hi_d = neg_rem_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        end else begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end
endmodule
